// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared output-layer types, default geometry and score slice helper
package ann_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } ann_state_t;

    localparam int ANN_N_CLASSES = 10;
    localparam int ANN_DW        = 8;
    localparam int ANN_LW        = 4;

    // Class k score from a packed output-layer vector of the default geometry
    function automatic logic signed [ANN_DW-1:0] ann_score(
        input logic [ANN_N_CLASSES*ANN_DW-1:0] data,
        input int unsigned                     k
    );
        return ANN_DW'(data >> (k * ANN_DW));
    endfunction

endpackage

// File: rtl/ann_result_collector_if.sv
// rtl/ann_result_collector_if.sv - sample input and classification result bundle
interface ann_result_collector_if
    import ann_pkg::*;
#(
    parameter int N_CLASSES = ANN_N_CLASSES,
    parameter int DW        = ANN_DW,
    parameter int LW        = ANN_LW,
    parameter int CW        = 10
);
    logic                   out_ready;
    logic [N_CLASSES*DW-1:0] out_data;
    logic [LW-1:0]          label;

    logic [LW-1:0]          predicted;
    logic                   pred_valid;
    logic                   correct;
    logic [CW-1:0]          correct_count;
    logic [CW-1:0]          sample_count;
    logic                   busy;
    logic                   done;
    logic                   overrun;

    modport master (
        output out_ready, out_data, label,
        input  predicted, pred_valid, correct, correct_count, sample_count,
               busy, done, overrun
    );

    modport slave (
        input  out_ready, out_data, label,
        output predicted, pred_valid, correct, correct_count, sample_count,
               busy, done, overrun
    );
endinterface

// File: rtl/ann_argmax_step.sv
// rtl/ann_argmax_step.sv - signed strict compare of a candidate score against the running best
module ann_argmax_step #(
    parameter int DW = 8
) (
    input  logic signed [DW-1:0] cand,
    input  logic signed [DW-1:0] best,
    output logic                 take
);
    // Strict greater-than so ties keep the earlier (lower) index
    assign take = (cand > best);
endmodule

// File: rtl/ann_result_collector.sv
// rtl/ann_result_collector.sv - per-sample argmax scan and running accuracy counters
module ann_result_collector
    import ann_pkg::*;
#(
    parameter int N_SAMPLES = 750,
    parameter int N_CLASSES = ANN_N_CLASSES,
    parameter int DW        = ANN_DW,
    parameter int LW        = ANN_LW,
    parameter int CW        = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    ann_result_collector_if.slave  bus
);
    ann_state_t              state, state_next;
    logic [N_CLASSES*DW-1:0] data_q;
    logic [LW-1:0]           label_q;
    logic signed [DW-1:0]    best_val;
    logic [LW-1:0]           best_idx;
    logic [LW-1:0]           idx;
    logic [LW-1:0]           predicted_q;
    logic                    correct_q;
    logic                    pred_valid_q;
    logic                    overrun_q;
    logic [CW-1:0]           correct_cnt;
    logic [CW-1:0]           sample_cnt;
    logic [CW-1:0]           sample_cnt_next;
    logic signed [DW-1:0]    cand;
    logic                    take;
    logic                    match;

    assign cand            = DW'(data_q >> (int'(idx) * DW));
    assign match           = (best_idx == label_q);
    assign sample_cnt_next = sample_cnt + CW'(1);

    ann_argmax_step #(.DW(DW)) u_step (
        .cand (cand),
        .best (best_val),
        .take (take)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (bus.out_ready) state_next = S_SCAN;
                S_SCAN:    if (idx == LW'(N_CLASSES - 1)) state_next = S_COMPARE;
                S_COMPARE: state_next = (sample_cnt_next == CW'(N_SAMPLES)) ? S_DONE : S_IDLE;
                default:   state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            label_q      <= '0;
            best_val     <= '0;
            best_idx     <= '0;
            idx          <= '0;
            predicted_q  <= '0;
            correct_q    <= 1'b0;
            pred_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            correct_cnt  <= '0;
            sample_cnt   <= '0;
        end else begin
            pred_valid_q <= 1'b0;
            if (start) begin
                // Coincident out_ready is dropped; predicted/correct keep the last result
                overrun_q   <= 1'b0;
                correct_cnt <= '0;
                sample_cnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: if (bus.out_ready) begin
                        data_q   <= bus.out_data;
                        label_q  <= bus.label;
                        best_val <= bus.out_data[DW-1:0];
                        best_idx <= '0;
                        idx      <= LW'(1);
                    end
                    S_SCAN: begin
                        if (take) begin
                            best_val <= cand;
                            best_idx <= idx;
                        end
                        idx <= idx + LW'(1);
                        if (bus.out_ready) overrun_q <= 1'b1;
                    end
                    S_COMPARE: begin
                        predicted_q  <= best_idx;
                        correct_q    <= match;
                        pred_valid_q <= 1'b1;
                        sample_cnt   <= sample_cnt_next;
                        correct_cnt  <= correct_cnt + CW'(match);
                        if (bus.out_ready) overrun_q <= 1'b1;
                    end
                    default: if (bus.out_ready) overrun_q <= 1'b1;
                endcase
            end
        end
    end

    assign bus.predicted     = predicted_q;
    assign bus.pred_valid    = pred_valid_q;
    assign bus.correct       = correct_q;
    assign bus.correct_count = correct_cnt;
    assign bus.sample_count  = sample_cnt;
    assign bus.busy          = (state == S_SCAN) || (state == S_COMPARE);
    assign bus.done          = (state == S_DONE);
    assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_ann_result_collector.sv
// tb/tb_ann_result_collector.sv - scoreboard bench for the output-layer result collector
module tb_ann_result_collector;
    localparam int NC = 10;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int CW = 10;
    localparam int NS = 4;

    typedef struct {
        logic [LW-1:0] pred;
        logic          corr;
    } exp_t;

    logic clk;
    logic rst_n;
    logic start;
    exp_t sb[$];
    int   checks;
    int   failures;

    ann_result_collector_if #(.N_CLASSES(NC), .DW(DW), .LW(LW), .CW(CW)) bus ();

    ann_result_collector #(
        .N_SAMPLES (NS),
        .N_CLASSES (NC),
        .DW        (DW),
        .LW        (LW),
        .CW        (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_sample(input int s[NC], input logic [LW-1:0] lab, input bit track);
        logic [NC*DW-1:0] d;
        int               v;
        int               best;
        int               bi;
        exp_t             e;
        for (int k = 0; k < NC; k++) begin
            v = s[k];
            d[k*DW +: DW] = v[DW-1:0];
        end
        best = s[0];
        bi   = 0;
        for (int k = 1; k < NC; k++) begin
            if (s[k] > best) begin
                best = s[k];
                bi   = k;
            end
        end
        e.pred = LW'(bi);
        e.corr = (LW'(bi) == lab);
        if (track) sb.push_back(e);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.out_data  = d;
        bus.label     = lab;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic wait_pred(output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.pred_valid) got = 1'b1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.predicted, bus.pred_valid, bus.correct, bus.correct_count, bus.sample_count,
             bus.busy, bus.done, bus.overrun} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got pred=%0d pv=%0b corr=%0b cc=%0d sc=%0d busy=%0b done=%0b ovr=%0b, want all 0",
                     bus.predicted, bus.pred_valid, bus.correct, bus.correct_count, bus.sample_count,
                     bus.busy, bus.done, bus.overrun);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int   s[NC];
        bit   got;
        int   lat;
        exp_t e;
        pulse_start();
        s = '{3, -2, 7, 1, 0, 0, 0, 0, 0, -5};
        send_sample(s, 4'd2, 1'b1);
        wait_pred(got, lat);
        checks++;
        if (!got || lat != NC) begin
            failures++;
            $display("FAIL single_latency: got seen=%0b lat=%0d, want seen=1 lat=%0d", got, lat, NC);
        end
        if (got) begin
            e = sb.pop_front();
            checks++;
            if (bus.predicted !== e.pred || bus.correct !== e.corr) begin
                failures++;
                $display("FAIL single_result: got pred=%0d corr=%0b, want pred=%0d corr=%0b",
                         bus.predicted, bus.correct, e.pred, e.corr);
            end
            checks++;
            if (bus.correct_count !== 10'd1 || bus.sample_count !== 10'd1) begin
                failures++;
                $display("FAIL single_counts: got cc=%0d sc=%0d, want cc=1 sc=1",
                         bus.correct_count, bus.sample_count);
            end
            @(negedge clk);
            checks++;
            if (bus.pred_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_pulse_width: got pv=%0b, want 0", bus.pred_valid);
            end
        end
    endtask

    task automatic test_ties();
        int   s[NC];
        bit   got;
        int   lat;
        exp_t e;
        pulse_start();
        for (int k = 0; k < NC; k++) s[k] = -128;
        s[4] = 127;
        s[7] = 127;
        send_sample(s, 4'd4, 1'b1);
        wait_pred(got, lat);
        checks++;
        if (!got || bus.predicted !== sb[0].pred || bus.predicted !== 4'd4 || bus.correct !== 1'b1) begin
            failures++;
            $display("FAIL tie_high: got seen=%0b pred=%0d corr=%0b, want pred=4 corr=1",
                     got, bus.predicted, bus.correct);
        end
        if (sb.size() > 0) e = sb.pop_front();
        for (int k = 0; k < NC; k++) s[k] = -1;
        send_sample(s, 4'd5, 1'b1);
        wait_pred(got, lat);
        e = sb.pop_front();
        checks++;
        if (!got || bus.predicted !== e.pred || bus.correct !== e.corr) begin
            failures++;
            $display("FAIL tie_all_neg: got seen=%0b pred=%0d corr=%0b, want pred=%0d corr=%0b",
                     got, bus.predicted, bus.correct, e.pred, e.corr);
        end
    endtask

    task automatic test_full_run();
        int   s[NC];
        int   pk[4];
        int   lb[4];
        bit   got;
        int   lat;
        int   pv_seen;
        exp_t e;
        pk = '{1, 3, 9, 5};
        lb = '{1, 0, 9, 2};
        pulse_start();
        for (int i = 0; i < NS; i++) begin
            for (int k = 0; k < NC; k++) s[k] = k - 20;
            s[pk[i]] = 50;
            send_sample(s, LW'(lb[i]), 1'b1);
            wait_pred(got, lat);
            e = sb.pop_front();
            checks++;
            if (!got || bus.predicted !== e.pred || bus.correct !== e.corr ||
                bus.sample_count !== CW'(i + 1) || bus.done !== (i == NS - 1)) begin
                failures++;
                $display("FAIL run_sample%0d: got seen=%0b pred=%0d corr=%0b sc=%0d done=%0b, want pred=%0d corr=%0b sc=%0d done=%0b",
                         i, got, bus.predicted, bus.correct, bus.sample_count, bus.done,
                         e.pred, e.corr, i + 1, (i == NS - 1));
            end
        end
        checks++;
        if (bus.correct_count !== 10'd2) begin
            failures++;
            $display("FAIL run_correct_count: got %0d, want 2", bus.correct_count);
        end
        send_sample(s, 4'd0, 1'b0);
        pv_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.pred_valid) pv_seen++;
        end
        checks++;
        if (pv_seen != 0 || bus.overrun !== 1'b1 || bus.sample_count !== 10'd4 ||
            bus.correct_count !== 10'd2 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL run_extra_sample: got pv=%0d ovr=%0b sc=%0d cc=%0d done=%0b, want pv=0 ovr=1 sc=4 cc=2 done=1",
                     pv_seen, bus.overrun, bus.sample_count, bus.correct_count, bus.done);
        end
    endtask

    task automatic test_overrun_scan();
        int   s[NC];
        int   t[NC];
        bit   got;
        int   lat;
        exp_t e;
        pulse_start();
        s = '{-10, 20, 5, -3, 19, 0, 2, -100, 8, 20};
        send_sample(s, 4'd1, 1'b1);
        @(negedge clk);
        for (int k = 0; k < NC; k++) t[k] = 0;
        t[8] = 100;
        send_sample(t, 4'd8, 1'b0);
        wait_pred(got, lat);
        e = sb.pop_front();
        checks++;
        if (!got || bus.predicted !== e.pred || bus.correct !== e.corr || bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_scan: got seen=%0b pred=%0d corr=%0b ovr=%0b, want pred=%0d corr=%0b ovr=1",
                     got, bus.predicted, bus.correct, bus.overrun, e.pred, e.corr);
        end
    endtask

    task automatic test_start_abort();
        int   s[NC];
        bit   got;
        int   lat;
        int   pv_seen;
        exp_t e;
        for (int k = 0; k < NC; k++) s[k] = 0;
        s[3] = 9;
        send_sample(s, 4'd3, 1'b0);
        @(negedge clk);
        s[3] = 0;
        s[2] = 9;
        bus.out_ready = 1'b1;
        bus.out_data  = '0;
        bus.label     = 4'd2;
        start         = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        start         = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.sample_count !== 10'd0 || bus.correct_count !== 10'd0 ||
            bus.overrun !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_clear: got busy=%0b sc=%0d cc=%0d ovr=%0b done=%0b, want all 0",
                     bus.busy, bus.sample_count, bus.correct_count, bus.overrun, bus.done);
        end
        pv_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.pred_valid || bus.busy) pv_seen++;
        end
        checks++;
        if (pv_seen != 0) begin
            failures++;
            $display("FAIL abort_quiet: got %0d active cycles, want 0", pv_seen);
        end
        for (int k = 0; k < NC; k++) s[k] = -k;
        s[6] = 40;
        send_sample(s, 4'd6, 1'b1);
        wait_pred(got, lat);
        e = sb.pop_front();
        checks++;
        if (!got || lat != NC || bus.predicted !== e.pred || bus.correct !== e.corr ||
            bus.sample_count !== 10'd1 || bus.correct_count !== 10'd1) begin
            failures++;
            $display("FAIL abort_next: got seen=%0b lat=%0d pred=%0d corr=%0b sc=%0d cc=%0d, want lat=%0d pred=%0d corr=%0b sc=1 cc=1",
                     got, lat, bus.predicted, bus.correct, bus.sample_count, bus.correct_count,
                     NC, e.pred, e.corr);
        end
    endtask

    task automatic test_async_reset();
        int s[NC];
        for (int k = 0; k < NC; k++) s[k] = k;
        send_sample(s, 4'd9, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre_busy: got %0b, want 1", bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.predicted, bus.pred_valid, bus.correct, bus.correct_count, bus.sample_count,
             bus.busy, bus.done, bus.overrun} !== '0) begin
            failures++;
            $display("FAIL areset_immediate: got pred=%0d corr=%0b cc=%0d sc=%0d busy=%0b, want all 0",
                     bus.predicted, bus.correct, bus.correct_count, bus.sample_count, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.sample_count !== 10'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL areset_after: got busy=%0b sc=%0d pending=%0d, want 0 0 0",
                     bus.busy, bus.sample_count, sb.size());
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b1;
        start         = 1'b0;
        bus.out_ready = 1'b0;
        bus.out_data  = '0;
        bus.label     = '0;
        test_reset();
        test_single();
        test_ties();
        test_full_run();
        test_overrun_scan();
        test_start_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
